// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle MIPS-subset CPU.
// Walks each instruction through fetch / decode / execute / memory /
// write-back and drives the datapath mux selects, enables and the 3-bit
// ALUOp handed to the ALU controller.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), async active-high reset
//   instr_op_i        opcode from IR (stable from DECODE to next FETCH)
//   funct_i           IR[5:0], only used to pick out jr
//   zero_i            ALU zero flag, resolves branches
//   mem_ready_i       memory finishes the current access this cycle
//   pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o  enables
//   iord_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, pc_src_o
//                     datapath mux selects
//   alu_op_o          ALUOp class for the ALU controller
//   illegal_o         sticky illegal-opcode flag
//   state_o           current state (debug)
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_JR        = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state_reg, state_next;
  logic   illegal_reg;

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:     state_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:                      state_next = (funct_i == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                  state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                state_next = S_BRANCH;
          OP_J, OP_JAL:                  state_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_next = S_EXEC_I;
          default:                       state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  state_next = (instr_op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_next = S_R_WB;
      S_R_WB:      state_next = S_FETCH;
      S_EXEC_I:    state_next = S_I_WB;
      S_I_WB:      state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JUMP:      state_next = S_FETCH;
      S_JR:        state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_TRAP)
        illegal_reg <= 1'b1;
    end
  end

  // Output decode. Everything is a function of the state register except the
  // FETCH load enables (follow mem_ready_i) and the BRANCH pc_write (follows
  // zero_i). The whole block is gated by rst_i so that an asynchronous reset
  // drops every strobe in the same cycle, even though the reset state (FETCH)
  // would otherwise assert mem_read.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'b00;
    mem_to_reg_o = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    if (!rst_i) begin
      case (state_reg)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE:   alu_src_b_o = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        S_MEM_READ: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 2'b01;
        end
        S_MEM_WRITE: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b010;
        end
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 2'b01;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          case (instr_op_i)
            OP_SLTI: alu_op_o = 3'b011;
            OP_ORI:  alu_op_o = 3'b100;
            OP_LUI:  alu_op_o = 3'b110;
            default: alu_op_o = 3'b101;
          endcase
        end
        S_I_WB:     reg_write_o = 1'b1;
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          pc_src_o    = 2'b01;
          if (instr_op_i == OP_BNE) begin
            alu_op_o   = 3'b111;
            pc_write_o = ~zero_i;
          end else begin
            alu_op_o   = 3'b001;
            pc_write_o = zero_i;
          end
        end
        S_JUMP: begin
          pc_src_o   = 2'b10;
          pc_write_o = 1'b1;
          // jal links into $31 with the PC, which FETCH already advanced
          if (instr_op_i == OP_JAL) begin
            reg_write_o  = 1'b1;
            reg_dst_o    = 2'b10;
            mem_to_reg_o = 2'b10;
          end
        end
        S_JR: begin
          pc_src_o   = 2'b11;
          pc_write_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal_o = illegal_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. All outputs are packed
// into one vector and compared each cycle against hand-written expectations.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] instr_op_i = 6'd0;
  logic [5:0] funct_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic       pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o;
  logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
  logic       alu_src_a_o, illegal_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
    .ir_write_o(ir_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .iord_o(iord_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // {pcw, irw, mr, mw, iord, rw, reg_dst, mem_to_reg, asa, asb, alu_op, pc_src, illegal, state}
  logic [22:0] ctl;
  assign ctl = {pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o, reg_write_o,
                reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
                illegal_o, state_o};

  function automatic logic [22:0] c(input logic pcw, input logic irw, input logic mr,
                                    input logic mw, input logic io, input logic rw,
                                    input logic [1:0] rd, input logic [1:0] mtr,
                                    input logic asa, input logic [1:0] asb,
                                    input logic [2:0] aop, input logic [1:0] ps,
                                    input logic ill, input logic [3:0] st);
    return {pcw, irw, mr, mw, io, rw, rd, mtr, asa, asb, aop, ps, ill, st};
  endfunction

  logic [22:0] F1, F0, DEC, RST;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      mem_ready_i = (i == 1);
      #1;
      checks++;
      if (ctl !== RST) begin
        failures++;
        $display("FAIL reset cyc%0d ctl=%h required=%h", i, ctl, RST);
      end
    end
    // first cycle with rst_i low: fetch strobe up, not ready yet
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if (ctl !== F0) begin
      failures++;
      $display("FAIL reset_release ctl=%h required=%h", ctl, F0);
    end
  endtask

  task automatic test_rtype();
    logic [22:0] e [5];
    e = '{F1, DEC, c(0,0,0,0,0,0,0,0,1,0,3'd2,0,0,4'd6),
          c(0,0,0,0,0,1,2'd1,0,0,0,0,0,0,4'd7), F0};
    instr_op_i = 6'b000000; funct_i = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); mem_ready_i = (i == 0); #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL rtype cyc%0d ctl=%h required=%h", i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [22:0] e [8];
    logic        r [8];
    logic [22:0] mrd;
    mrd = c(0,0,1,0,1,0,0,0,0,0,0,0,0,4'd3);
    e = '{F1, DEC, c(0,0,0,0,0,0,0,0,1,2'd2,0,0,0,4'd2), mrd, mrd, mrd,
          c(0,0,0,0,0,1,0,2'd1,0,0,0,0,0,4'd4), F0};
    r = '{1, 1, 1, 0, 0, 1, 1, 0};
    instr_op_i = 6'b100011; funct_i = 6'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i); mem_ready_i = r[i]; #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL lw_wait cyc%0d ctl=%h required=%h", i, ctl, e[i]);
      end
    end
  endtask

  // op, zero flag, expected BRANCH-cycle vector
  task automatic test_branch(input logic [5:0] op, input logic z, input logic [22:0] eb);
    logic [22:0] e [4];
    e = '{F1, DEC, eb, F0};
    instr_op_i = op; zero_i = z;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); mem_ready_i = (i == 0); #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL branch op=%b z=%0d cyc%0d ctl=%h required=%h", op, z, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_jump(input logic [5:0] op, input logic [5:0] fn, input logic [22:0] ej);
    logic [22:0] e [4];
    e = '{F1, DEC, ej, F0};
    instr_op_i = op; funct_i = fn;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); mem_ready_i = (i == 0); #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL jump op=%b cyc%0d ctl=%h required=%h", op, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_itype(input logic [5:0] op, input logic [2:0] aop);
    logic [22:0] e [5];
    e = '{F1, DEC, c(0,0,0,0,0,0,0,0,1,2'd2,aop,0,0,4'd10),
          c(0,0,0,0,0,1,0,0,0,0,0,0,0,4'd11), F0};
    instr_op_i = op;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); mem_ready_i = (i == 0); #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL itype op=%b cyc%0d ctl=%h required=%h", op, i, ctl, e[i]);
      end
    end
  endtask

  task automatic test_trap();
    logic [22:0] tr;
    tr = c(0,0,0,0,0,0,0,0,0,0,0,0,1,4'd13);
    instr_op_i = 6'b111111;
    @(negedge clk_i); mem_ready_i = 1'b1; #1;
    checks++;
    if (ctl !== F1) begin failures++; $display("FAIL trap_fetch ctl=%h required=%h", ctl, F1); end
    @(negedge clk_i); #1;
    checks++;
    if (ctl !== DEC) begin failures++; $display("FAIL trap_decode ctl=%h required=%h", ctl, DEC); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i); mem_ready_i = i[0]; zero_i = i[1]; #1;
      checks++;
      if (ctl !== tr) begin
        failures++;
        $display("FAIL trap_hold cyc%0d ctl=%h required=%h", i, ctl, tr);
      end
    end
    @(negedge clk_i); rst_i = 1'b1; #1;
    checks++;
    if (ctl !== RST) begin failures++; $display("FAIL trap_reset ctl=%h required=%h", ctl, RST); end
    @(negedge clk_i); rst_i = 1'b0; mem_ready_i = 1'b0; #1;
    checks++;
    if (ctl !== F0) begin failures++; $display("FAIL trap_release ctl=%h required=%h", ctl, F0); end
  endtask

  task automatic test_sw_reset();
    logic [22:0] e [5];
    logic [22:0] mwr;
    mwr = c(0,0,0,1,1,0,0,0,0,0,0,0,0,4'd5);
    e = '{F1, DEC, c(0,0,0,0,0,0,0,0,1,2'd2,0,0,0,4'd2), mwr, mwr};
    instr_op_i = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); mem_ready_i = (i < 3); #1;
      checks++;
      if (ctl !== e[i]) begin
        failures++;
        $display("FAIL sw cyc%0d ctl=%h required=%h", i, ctl, e[i]);
      end
    end
    // reset lands mid-wait, asserted right after the clock edge
    @(posedge clk_i); #2; rst_i = 1'b1; #1;
    checks++;
    if (ctl !== RST) begin failures++; $display("FAIL sw_reset ctl=%h required=%h", ctl, RST); end
    @(negedge clk_i); rst_i = 1'b0; mem_ready_i = 1'b0; #1;
    checks++;
    if (ctl !== F0) begin failures++; $display("FAIL sw_release ctl=%h required=%h", ctl, F0); end
  endtask

  // BRANCH pc_write follows zero_i within the cycle
  task automatic test_branch_comb();
    instr_op_i = 6'b000100;
    zero_i = 1'b0;
    @(negedge clk_i); mem_ready_i = 1'b1; #1;
    @(negedge clk_i); mem_ready_i = 1'b0; #1;
    @(negedge clk_i); #1;
    checks++;
    if (pc_write_o !== 1'b0 || state_o !== 4'd8) begin
      failures++;
      $display("FAIL beq_z0 pc_write=%b state=%0d required 0/8", pc_write_o, state_o);
    end
    zero_i = 1'b1; #1;
    checks++;
    if (pc_write_o !== 1'b1) begin
      failures++;
      $display("FAIL beq_z1_comb pc_write=%b required 1", pc_write_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (ctl !== F0) begin failures++; $display("FAIL beq_back ctl=%h required=%h", ctl, F0); end
  endtask

  initial begin
    F1  = c(1,1,1,0,0,0,0,0,0,2'd1,0,0,0,4'd0);
    F0  = c(0,0,1,0,0,0,0,0,0,2'd1,0,0,0,4'd0);
    DEC = c(0,0,0,0,0,0,0,0,0,2'd3,0,0,0,4'd1);
    RST = '0;

    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch(6'b000100, 1'b1, c(1,0,0,0,0,0,0,0,1,0,3'd1,2'd1,0,4'd8));
    test_branch(6'b000101, 1'b1, c(0,0,0,0,0,0,0,0,1,0,3'd7,2'd1,0,4'd8));
    test_branch(6'b000101, 1'b0, c(1,0,0,0,0,0,0,0,1,0,3'd7,2'd1,0,4'd8));
    test_branch_comb();
    test_jump(6'b000011, 6'd0, c(1,0,0,0,0,1,2'd2,2'd2,0,0,0,2'd2,0,4'd9));
    test_jump(6'b000010, 6'd0, c(1,0,0,0,0,0,0,0,0,0,0,2'd2,0,4'd9));
    test_jump(6'b000000, 6'b001000, c(1,0,0,0,0,0,0,0,0,0,0,2'd3,0,4'd12));
    test_itype(6'b001000, 3'b101);
    test_itype(6'b001010, 3'b011);
    test_itype(6'b001101, 3'b100);
    test_itype(6'b001111, 3'b110);
    test_sw_reset();
    test_trap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control FSM for the MIPS-subset CPU. Sequences each instruction through fetch, decode, execute, memory and write-back states; drives datapath muxes and enables, and produces the 3-bit ALUOp consumed by the ALU controller, which decodes it with funct. Sits between the instruction register and the datapath, with a ready handshake to unified instruction/data memory.

## Interface
- No parameters; all encodings fixed below.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_op_i  in  6  opcode from IR; stable from DECODE until next FETCH.
- funct_i  in  6  IR[5:0].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes current access this cycle.
- pc_write_o  out  1  PC load enable.
- ir_write_o  out  1  IR load enable.
- mem_read_o / mem_write_o  out  1 each  memory strobes.
- iord_o  out  1  memory address: 0 = PC, 1 = ALUOut.
- reg_write_o  out  1  register file write enable.
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a_o  out  1  0 PC, 1 reg A.
- alu_src_b_o  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- alu_op_o  out  3  000 add, 001 sub, 010 R-type (funct), 011 slti, 100 ori, 101 addi, 110 lui, 111 bne.
- pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 reg A.
- illegal_o  out  1  sticky illegal-opcode flag.
- state_o  out  4  current state, debug.

## Operation
- States (state_o): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11, JR 12, TRAP 13.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read, alu_src_b=01, alu_op=000, pc_src=00; ir_write=pc_write=mem_ready_i. Stay until mem_ready_i=1, then DECODE.
- DECODE: alu_src_b=11, alu_op=000 (branch target to ALUOut). Next by opcode: 000000 -> JR if funct=001000 else EXEC_R; 100011/101011 -> MEM_ADDR; 000100/000101 -> BRANCH; 000010/000011 -> JUMP; 001000/001010/001101/001111 -> EXEC_I; other -> TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; -> MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ: mem_read, iord=1; hold until mem_ready_i, then MEM_WB. MEM_WB: reg_write, reg_dst=00, mem_to_reg=01; -> FETCH.
- MEM_WRITE: mem_write, iord=1; hold until mem_ready_i, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010; -> R_WB: reg_write, reg_dst=01, mem_to_reg=00; -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op 101 addi / 011 slti / 100 ori / 110 lui; -> I_WB: reg_write, reg_dst=00, mem_to_reg=00; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_src=01; alu_op=001 beq / 111 bne; pc_write = beq&zero_i | bne&~zero_i (combinational on zero_i); -> FETCH.
- JUMP: pc_src=10, pc_write=1; jal additionally reg_write, reg_dst=10, mem_to_reg=10 (PC already = PC+4); -> FETCH.
- JR: pc_src=11, pc_write=1; -> FETCH.
- TRAP: illegal_o=1, all enables 0; terminal until reset.

## Timing
- Reset: state=FETCH, illegal_o=0; while rst_i=1 all enables/strobes (pc_write, ir_write, mem_read, mem_write, reg_write) forced 0, mux selects and alu_op 0. First fetch strobe in the cycle rst_i is low.
- Reset asserted mid-instruction (including during a memory wait): state to FETCH immediately, strobes drop same cycle, no write-back occurs.
- Cycle counts with zero wait states: branch/jump/jr 3, R-type/I-type/sw 4, lw 5; each mem_ready_i=0 cycle in FETCH/MEM_READ/MEM_WRITE adds one.
- Outputs are Moore except ir_write/pc_write in FETCH (mem_ready_i) and pc_write in BRANCH (zero_i).
- mem_read/mem_write held constant across wait cycles; never both 1.

## Test plan
- Reset then R-type add (op 000000, funct 100000), ready=1: states 0,1,6,7,0; alu_op=010 in state 6; reg_write=1, reg_dst=01 only in state 7.
- lw with mem_ready_i low 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0; mem_read, iord=1 stable across waits; reg_write, mem_to_reg=01 in state 4.
- beq zero_i=1 -> pc_write=1, pc_src=01, alu_op=001; bne with zero_i=1 -> pc_write=0, alu_op=111.
- jal: state 9 drives pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; jr (funct 001000): state 12, pc_src=11.
- Opcode 111111: DECODE -> TRAP, illegal_o=1 and all enables 0 for 10+ cycles; rst_i clears to FETCH, illegal_o=0.
- rst_i pulsed in MEM_WRITE during wait: mem_write drops same cycle, state_o=0, no write completes.
